// File: rtl/filter_operation_pipe.sv
// Four-stage window filter: centre pass, Sobel magnitude, erode (min), dilate (max).
// Define FILTER_THRESH_EN to binarise the stage-4 pixel against thresh.
module filter_operation_pipe #(
  parameter int Ope_Size    = 3,
  parameter int Pix_W       = 8,
  parameter int Sobel_Shift = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  reflesh,
  input  logic [(Pix_W+1)*Ope_Size*Ope_Size-1:0] data_bus,
  input  logic [1:0]                            mode,
  input  logic [Pix_W-1:0]                      thresh,
  output logic [Pix_W:0]                        out
);

  localparam int N  = Ope_Size;
  localparam int C  = N / 2;
  localparam int O  = C - 1;
  localparam int EW = Pix_W + 1;
  localparam int SW = Pix_W + 2;
  localparam int GW = Pix_W + 4;
  localparam logic [Pix_W-1:0] PMAX = '1;

  typedef logic [Pix_W-1:0]     pix_t;
  typedef logic [SW-1:0]        sum_t;
  typedef logic signed [GW-1:0] grad_t;
  typedef logic [GW-1:0]        mag_t;

  typedef struct packed {
    logic       v;
    logic [1:0] m;
    pix_t       c;
    sum_t       l;
    sum_t       r;
    sum_t       t;
    sum_t       b;
  } s1_t;

  typedef struct packed {
    logic       v;
    logic [1:0] m;
    pix_t       c;
    grad_t      gx;
    grad_t      gy;
    pix_t       mn;
    pix_t       mx;
  } s2_t;

  typedef struct packed {
    logic       v;
    logic [1:0] m;
    pix_t       c;
    mag_t       mag;
    pix_t       mn;
    pix_t       mx;
  } s3_t;

  function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
    return sum_t'(a) + (sum_t'(b) << 1) + sum_t'(c);
  endfunction

  function automatic mag_t gabs(input grad_t g);
    return g[GW-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

  pix_t px [N][N];

  for (genvar gy = 0; gy < N; gy++) begin : g_row
    for (genvar gx = 0; gx < N; gx++) begin : g_col
      assign px[gy][gx] = data_bus[(gy*N+gx)*EW +: Pix_W];
    end
  end

  logic vin;
  assign vin = data_bus[(C*N+C)*EW + Pix_W];

  // non-centre valid bits are deliberately ignored
  logic unused_bits;
  assign unused_bits = ^{data_bus, thresh};

  // stage 1: row/column partial sums and per-row extremes
  pix_t rmin [N];
  pix_t rmax [N];
  s1_t  s1_d, s1;
  pix_t s1_rmin [N];
  pix_t s1_rmax [N];

  always_comb begin
    for (int y = 0; y < N; y++) begin
      rmin[y] = px[y][0];
      rmax[y] = px[y][0];
      for (int x = 1; x < N; x++) begin
        if (px[y][x] < rmin[y]) rmin[y] = px[y][x];
        if (px[y][x] > rmax[y]) rmax[y] = px[y][x];
      end
    end
  end

  always_comb begin
    s1_d   = '0;
    s1_d.v = vin;
    s1_d.m = mode;
    s1_d.c = px[C][C];
    s1_d.l = wsum(px[O][O], px[O+1][O], px[O+2][O]);
    s1_d.r = wsum(px[O][O+2], px[O+1][O+2], px[O+2][O+2]);
    s1_d.t = wsum(px[O][O], px[O][O+1], px[O][O+2]);
    s1_d.b = wsum(px[O+2][O], px[O+2][O+1], px[O+2][O+2]);
  end

  // stage 2: gradients and cross-row reduction
  s2_t s2_d, s2;

  always_comb begin
    s2_d    = '0;
    s2_d.v  = s1.v;
    s2_d.m  = s1.m;
    s2_d.c  = s1.c;
    s2_d.gx = $signed({2'b00, s1.r}) - $signed({2'b00, s1.l});
    s2_d.gy = $signed({2'b00, s1.b}) - $signed({2'b00, s1.t});
    s2_d.mn = s1_rmin[0];
    s2_d.mx = s1_rmax[0];
    for (int y = 1; y < N; y++) begin
      if (s1_rmin[y] < s2_d.mn) s2_d.mn = s1_rmin[y];
      if (s1_rmax[y] > s2_d.mx) s2_d.mx = s1_rmax[y];
    end
  end

  // stage 3: magnitude
  s3_t s3_d, s3;

  always_comb begin
    s3_d     = '0;
    s3_d.v   = s2.v;
    s3_d.m   = s2.m;
    s3_d.c   = s2.c;
    s3_d.mag = gabs(s2.gx) + gabs(s2.gy);
    s3_d.mn  = s2.mn;
    s3_d.mx  = s2.mx;
  end

  // stage 4: mode select, optional binarise
  mag_t          sob_sh;
  pix_t          sob;
  pix_t          res;
  pix_t          pix_fin;
  logic [Pix_W:0] out_d;

  assign sob_sh = s3.mag >> Sobel_Shift;
  assign sob    = (|sob_sh[GW-1:Pix_W]) ? PMAX : sob_sh[Pix_W-1:0];

  always_comb begin
    res = s3.c;
    unique case (s3.m)
      2'd0: res = s3.c;
      2'd1: res = sob;
      2'd2: res = s3.mn;
      2'd3: res = s3.mx;
    endcase
  end

`ifdef FILTER_THRESH_EN
  assign pix_fin = (res >= thresh) ? PMAX : '0;
`else
  assign pix_fin = res;
`endif

  assign out_d = s3.v ? {1'b1, pix_fin} : '0;

  always_ff @(posedge clk) begin
    s1      <= s1_d;
    s1_rmin <= rmin;
    s1_rmax <= rmax;
    s2      <= s2_d;
    s3      <= s3_d;
    out     <= out_d;
    if (rst || reflesh) begin
      s1.v <= 1'b0;
      s2.v <= 1'b0;
      s3.v <= 1'b0;
      out  <= '0;
    end
  end

endmodule

// File: tb/tb_filter_operation_pipe.sv
// Scoreboard bench for filter_operation_pipe (3x3, 8-bit, shift 2).
// Honours FILTER_THRESH_EN when the design is built with it.
module tb_filter_operation_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reflesh = 1'b0;
  logic [80:0] data_bus = '0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  thresh = 8'h80;
  logic [8:0]  out;

  int checks = 0;
  int passed = 0;

  logic [8:0] exp_q [$];
  string      name_q [$];

  typedef logic [7:0] win_t [9];

  always #5 clk = ~clk;

  filter_operation_pipe #(
    .Ope_Size(3),
    .Pix_W(8),
    .Sobel_Shift(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reflesh(reflesh),
    .data_bus(data_bus),
    .mode(mode),
    .thresh(thresh),
    .out(out)
  );

  function automatic logic [8:0] bin(input logic [8:0] e);
`ifdef FILTER_THRESH_EN
    if (!e[8]) return 9'h000;
    return (e[7:0] >= thresh) ? 9'h1FF : 9'h100;
`else
    return e;
`endif
  endfunction

  function automatic logic [8:0] model(input win_t w, input logic v,
                                       input logic [1:0] m);
    int a [9];
    int gx, gy, s, r;
    if (!v) return 9'h000;
    for (int k = 0; k < 9; k++) a[k] = int'(w[k]);
    gx = (a[2] + 2*a[5] + a[8]) - (a[0] + 2*a[3] + a[6]);
    gy = (a[6] + 2*a[7] + a[8]) - (a[0] + 2*a[1] + a[2]);
    s = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> 2;
    if (s > 255) s = 255;
    r = a[4];
    if (m == 2'd1) r = s;
    if (m == 2'd2) for (int k = 0; k < 9; k++) if (a[k] < r) r = a[k];
    if (m == 2'd3) for (int k = 0; k < 9; k++) if (a[k] > r) r = a[k];
    return bin({1'b1, 8'(r)});
  endfunction

  function automatic win_t rnd_win();
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'($urandom);
    return w;
  endfunction

  task automatic drive(input win_t w, input logic v, input logic [1:0] m,
                       input logic r, input logic f,
                       input logic [8:0] e, input string n);
    for (int k = 0; k < 9; k++)
      data_bus[k*9 +: 9] = {(k == 4) ? v : 1'($urandom), w[k]};
    mode = m;
    rst = r;
    reflesh = f;
    if (r || f) begin
      foreach (exp_q[i]) begin
        exp_q[i] = 9'h000;
        name_q[i] = "flushed";
      end
      exp_q.push_back(9'h000);
    end else begin
      exp_q.push_back(e);
    end
    name_q.push_back(n);
  endtask

  task automatic test_reset();
    win_t w;
    logic [1:0] m;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      w = rnd_win();
      m = 2'($urandom);
      if (i < 2) drive(w, 1'b1, m, 1'b1, 1'b0, 9'h000, "reset_hold");
      else drive(w, 1'b1, m, 1'b0, 1'b0, model(w, 1'b1, m), "reset_release");
    end
  endtask

  task automatic test_pass();
    win_t w;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      w = rnd_win();
      w[4] = 8'h5A;
      if (i == 0) drive(w, 1'b1, 2'd0, 1'b0, 1'b0, bin(9'h15A), "pass_valid");
      else drive(w, 1'b0, 2'd0, 1'b0, 1'b0, 9'h000, "pass_invalid");
    end
  endtask

  task automatic test_sobel();
    win_t ws [4];
    logic [8:0] es [4];
    string ns [4];
    ws[0] = '{8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255};
    ws[1] = '{8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77, 8'd77};
    ws[2] = '{8'd0, 8'd0, 8'd0, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40};
    ws[3] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255};
    es[0] = 9'h1FF; ns[0] = "sobel_hedge";
    es[1] = 9'h100; ns[1] = "sobel_flat";
    es[2] = 9'h128; ns[2] = "sobel_vstep";
    es[3] = 9'h1FF; ns[3] = "sobel_saturate";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      drive(ws[i], 1'b1, 2'd1, 1'b0, 1'b0, bin(es[i]), ns[i]);
    end
  endtask

  task automatic test_minmax();
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'(k + 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      if (i % 2 == 0) drive(w, 1'b1, 2'd2, 1'b0, 1'b0, bin(9'h101), "min");
      else drive(w, 1'b1, 2'd3, 1'b0, 1'b0, bin(9'h109), "max");
    end
  endtask

  task automatic test_back_to_back();
    win_t w;
    logic v;
    logic [1:0] m;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      w = rnd_win();
      v = ($urandom_range(0, 3) != 0);
      m = 2'($urandom);
      drive(w, v, m, 1'b0, 1'b0, model(w, v, m), "back_to_back");
    end
  endtask

  task automatic test_flush();
    win_t w;
    logic [1:0] m;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      w = rnd_win();
      m = 2'($urandom);
      if (i == 4) begin
        drive(w, 1'b1, m, 1'b0, 1'b1, 9'h000, "flush_drop");
      end else if (i == 5) begin
        w[4] = 8'h33;
        drive(w, 1'b1, 2'd0, 1'b0, 1'b0, bin(9'h133), "flush_after");
      end else begin
        drive(w, 1'b1, m, 1'b0, 1'b0, model(w, 1'b1, m), "flush_stream");
      end
    end
  endtask

  task automatic test_thresh();
    win_t w;
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      w = rnd_win();
      w[4] = (i == 0) ? 8'h7F : 8'h80;
`ifdef FILTER_THRESH_EN
      e = (i == 0) ? 9'h100 : 9'h1FF;
`else
      e = (i == 0) ? 9'h17F : 9'h180;
`endif
      drive(w, 1'b1, 2'd0, 1'b0, 1'b0, e, "thresh");
    end
  endtask

  task automatic test_drain();
    win_t w;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q[0])
        $display("FAIL %s: out=%h required=%h", name_q[0], out, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      w = rnd_win();
      drive(w, 1'b0, 2'($urandom), 1'b0, 1'b0, 9'h000, "drain");
    end
  endtask

  initial begin
    @(posedge clk);
    repeat (4) begin
      exp_q.push_back(9'h000);
      name_q.push_back("reset_initial");
    end
    test_reset();
    test_pass();
    test_sobel();
    test_minmax();
    test_back_to_back();
    test_flush();
    test_thresh();
    test_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
